// File: rtl/data_sync_pkg.sv
// Shared definitions for the DATA_SYNC launcher family: state encoding
// and default word width.
package data_sync_pkg;

    // Default width of the launched data word
    localparam int DEFAULT_BUS_WIDTH = 8;

    // 2-bit state encoding shared by current and future launcher variants
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] HOLD = 2'b01;
    localparam logic [1:0] GAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_HOLD = HOLD,
        ST_GAP  = GAP
    } tx_state_t;

endpackage

// File: rtl/data_sync_tx_cnt.sv
// Loadable down-counter that saturates at zero, shared by the hold and
// gap phases of the launcher. The zero flag is combinational from the
// count so the controller can act on it in the same cycle.
module data_sync_tx_cnt #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 srst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count_reg;

    // Load has priority over decrement; decrement stops at zero so the
    // count can never wrap.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/data_sync_tx.sv
// Source-domain launcher for the DATA_SYNC multi-bit synchronizer.
// Accepts a word over valid/ready, drives it onto Unsync_bus, raises
// bus_enable for HOLD_CYCLES cycles, then keeps the data frozen for a
// GAP_CYCLES guard gap before signalling completion.
module data_sync_tx
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH   = DEFAULT_BUS_WIDTH,
    parameter int HOLD_CYCLES = 6,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [BUS_WIDTH-1:0] Unsync_bus,
    output logic                 bus_enable,
    output logic                 busy,
    output logic                 done_pulse
);

    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);

    tx_state_t            state_reg;
    logic [BUS_WIDTH-1:0] bus_reg;
    logic                 enable_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_load_value;
    logic                 cnt_dec;
    logic                 cnt_zero;

    // Counter control: load the hold length on accept, the gap length
    // when the hold phase expires, otherwise count down while active.
    always_comb begin
        cnt_load       = 1'b0;
        cnt_load_value = HOLD_LOAD;
        cnt_dec        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_load       = tx_valid;
                cnt_load_value = HOLD_LOAD;
            end
            ST_HOLD: begin
                cnt_load       = cnt_zero;
                cnt_load_value = GAP_LOAD;
                cnt_dec        = !cnt_zero;
            end
            ST_GAP: begin
                cnt_dec        = !cnt_zero;
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    data_sync_tx_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk        (CLK),
        .srst_n     (RST),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // Launch FSM with registered outputs; the data register only loads
    // on accept, so it is frozen through both HOLD and GAP.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg  <= ST_IDLE;
            bus_reg    <= '0;
            enable_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (tx_valid) begin
                        bus_reg    <= tx_data;
                        enable_reg <= 1'b1;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        enable_reg <= 1'b0;
                        state_reg  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    enable_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = (state_reg == ST_IDLE);
    assign Unsync_bus = bus_reg;
    assign bus_enable = enable_reg;
    assign busy       = busy_reg;
    assign done_pulse = done_reg;

endmodule

// File: tb/tb_data_sync_tx.sv
// Directed testbench for data_sync_tx: default configuration plus two
// parameter-corner instances (1/1 and 16/2).
module tb_data_sync_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance
    logic [7:0] d0, b0;
    logic       v0, r0, e0, busy0, dn0;
    // HOLD=1, GAP=1
    logic [7:0] d1, b1;
    logic       v1, r1, e1, busy1, dn1;
    // HOLD=16, GAP=2, CNT_WIDTH=4
    logic [7:0] d2, b2;
    logic       v2, r2, e2, busy2, dn2;

    int checks = 0;
    int errors = 0;

    data_sync_tx dut0 (
        .CLK(clk), .RST(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
        .Unsync_bus(b0), .bus_enable(e0), .busy(busy0), .done_pulse(dn0)
    );

    data_sync_tx #(.BUS_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_WIDTH(4)) dut1 (
        .CLK(clk), .RST(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
        .Unsync_bus(b1), .bus_enable(e1), .busy(busy1), .done_pulse(dn1)
    );

    data_sync_tx #(.BUS_WIDTH(8), .HOLD_CYCLES(16), .GAP_CYCLES(2), .CNT_WIDTH(4)) dut2 (
        .CLK(clk), .RST(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(r2),
        .Unsync_bus(b2), .bus_enable(e2), .busy(busy2), .done_pulse(dn2)
    );

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; v0 = 1'b1; d0 = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (b0 !== 8'h00 || e0 !== 1'b0 || busy0 !== 1'b0 || dn0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got bus=%h en=%b busy=%b done=%b want 00/0/0/0", i, b0, e0, busy0, dn0);
            end
        end
        v0 = 1'b0; rst = 1'b1;
        tick();
        checks++;
        if (r0 !== 1'b1 || e0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b en=%b want 1/0", r0, e0);
        end
        $display("reset: done");
    endtask

    task automatic test_single();
        logic exp_en, exp_done;
        d0 = 8'hF0; v0 = 1'b1;
        tick();
        v0 = 1'b0; d0 = 8'h00;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) tick();
            exp_en   = (i < 6);
            exp_done = (i == 8);
            checks++;
            if (e0 !== exp_en || dn0 !== exp_done || b0 !== 8'hF0 || r0 !== (i >= 8)) begin
                errors++;
                $display("FAIL single cyc=%0d got en=%b done=%b bus=%h ready=%b want en=%b done=%b bus=f0 ready=%b",
                         i, e0, dn0, b0, r0, exp_en, exp_done, (i >= 8));
            end
        end
        $display("single: word f0 launched");
    endtask

    task automatic test_busy_reject();
        d0 = 8'h55; v0 = 1'b1;
        tick();
        d0 = 8'hAA;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (b0 !== 8'h55) begin
                errors++;
                $display("FAIL busy_frozen cyc=%0d got bus=%h want 55", i, b0);
            end
        end
        checks++;
        if (dn0 !== 1'b1 || r0 !== 1'b1) begin
            errors++;
            $display("FAIL busy_done got done=%b ready=%b want 1/1", dn0, r0);
        end
        tick();
        v0 = 1'b0;
        checks++;
        if (b0 !== 8'hAA || e0 !== 1'b1 || dn0 !== 1'b0) begin
            errors++;
            $display("FAIL busy_accept2 got bus=%h en=%b done=%b want aa/1/0", b0, e0, dn0);
        end
        for (int j = 1; j <= 8; j++) tick();
        checks++;
        if (dn0 !== 1'b1 || b0 !== 8'hAA) begin
            errors++;
            $display("FAIL busy_complete2 got done=%b bus=%h want 1/aa", dn0, b0);
        end
        $display("busy_reject: aa held off then accepted");
    endtask

    task automatic test_back_to_back();
        logic       exp_en, exp_done;
        logic [7:0] exp_bus;
        int         enables;
        enables = 0;
        d0 = 8'h01; v0 = 1'b1;
        tick();
        d0 = 8'h02;
        for (int i = 0; i <= 26; i++) begin
            if (i > 0) tick();
            exp_en   = ((i % 9) < 6);
            exp_done = ((i % 9) == 8);
            exp_bus  = 8'(i / 9 + 1);
            if (e0 === 1'b1 && (i % 9) == 0) enables++;
            checks++;
            if (e0 !== exp_en || dn0 !== exp_done || b0 !== exp_bus) begin
                errors++;
                $display("FAIL b2b cyc=%0d got en=%b done=%b bus=%h want en=%b done=%b bus=%h",
                         i, e0, dn0, b0, exp_en, exp_done, exp_bus);
            end
            if (i == 9)  d0 = 8'h03;
            if (i == 18) v0 = 1'b0;
        end
        tick();
        checks++;
        if (enables != 3 || e0 !== 1'b0 || dn0 !== 1'b0 || r0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end got windows=%0d en=%b done=%b ready=%b want 3/0/0/1", enables, e0, dn0, r0);
        end
        $display("back_to_back: 01 02 03 launched");
    endtask

    task automatic test_reset_mid();
        d0 = 8'hCC; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (e0 !== 1'b0 || b0 !== 8'h00 || busy0 !== 1'b0 || dn0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset got en=%b bus=%h busy=%b done=%b want 0/00/0/0", e0, b0, busy0, dn0);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dn0 !== 1'b0 || e0 !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet cyc=%0d got done=%b en=%b want 0/0", i, dn0, e0);
            end
        end
        d0 = 8'hCC; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        checks++;
        if (dn0 !== 1'b1 || b0 !== 8'hCC) begin
            errors++;
            $display("FAIL midreset_relaunch got done=%b bus=%h want 1/cc", dn0, b0);
        end
        $display("reset_mid: aborted and relaunched cc");
    endtask

    task automatic test_corner_short();
        logic       exp_en, exp_done;
        logic [7:0] exp_bus;
        d1 = 8'hA1; v1 = 1'b1;
        tick();
        d1 = 8'hA2;
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) tick();
            exp_en   = (i < 6) && ((i % 3) == 0);
            exp_done = (i < 6) && ((i % 3) == 2);
            exp_bus  = (i < 3) ? 8'hA1 : 8'hA2;
            checks++;
            if (e1 !== exp_en || dn1 !== exp_done || b1 !== exp_bus) begin
                errors++;
                $display("FAIL short cyc=%0d got en=%b done=%b bus=%h want en=%b done=%b bus=%h",
                         i, e1, dn1, b1, exp_en, exp_done, exp_bus);
            end
            if (i == 3) v1 = 1'b0;
        end
        checks++;
        if (r1 !== 1'b1) begin
            errors++;
            $display("FAIL short_ready got %b want 1", r1);
        end
        $display("corner_short: hold=1 gap=1");
    endtask

    task automatic test_corner_long();
        int high;
        high = 0;
        d2 = 8'h5A; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        for (int i = 0; i <= 19; i++) begin
            if (i > 0) tick();
            if (e2 === 1'b1) high++;
            checks++;
            if (dn2 !== (i == 18) || e2 !== (i < 16) || b2 !== 8'h5A) begin
                errors++;
                $display("FAIL long cyc=%0d got en=%b done=%b bus=%h want en=%b done=%b bus=5a",
                         i, e2, dn2, b2, (i < 16), (i == 18));
            end
        end
        checks++;
        if (high != 16 || r2 !== 1'b1) begin
            errors++;
            $display("FAIL long_window got high=%0d ready=%b want 16/1", high, r2);
        end
        $display("corner_long: hold=16 window");
    endtask

    initial begin
        v1 = 1'b0; d1 = 8'h00;
        v2 = 1'b0; d2 = 8'h00;
        test_reset();
        test_single();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        test_corner_short();
        test_corner_long();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
